bus_xfer_unit: RTL and testbench
================================

# bus_xfer_unit

Parametrised successor to the single-bus datapath: a bank of NREGS general registers, a HI register, Y/Z ALU staging registers and one shared bus, driven by an internal three-phase sequencer instead of raw per-register enable and select lines. A command port (valid/ready) issues one register-transfer or ALU instruction at a time. The unit sequences bus-source selection, Y/Z loading and the destination write, so the future control unit only has to issue commands. It sits between the instruction decode logic and the register bank and ALU of the CPU.

## Interface
- WIDTH, 32, data/bus width in bits (≥4)
- NREGS, 16, number of general registers (power of 2, ≥2); index width AW = $clog2(NREGS)
- R0_ZERO, 0, when 1: R0 always reads 0 and writes to R0 are discarded

- clock  in  1  single clock, rising-edge
- clear  in  1  reset, asynchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit can accept a command (high only in IDLE)
- cmd_op  in  3  0 MOV, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 MUL, 7 MFHI
- cmd_src_a  in  AW  operand A register index
- cmd_src_b  in  AW  operand B register index
- cmd_dst  in  AW  destination register index
- cmd_imm  in  WIDTH  immediate for LDI
- done  out  1  one-cycle pulse: result written this cycle's closing edge
- zero  out  1  registered; set on the write edge if the written value == 0
- bus_out  out  WIDTH  current bus contents (observability)
- dbg_sel  in  AW  debug read index
- dbg_data  out  WIDTH  combinational read of register dbg_sel (0 for R0 when R0_ZERO)
- hi_data  out  WIDTH  HI register contents

## Operation
- States: IDLE, TA, TB, TW. IDLE→TA on cmd_valid&&cmd_ready; TA→TB→TW unconditionally; TW→IDLE.
- On accept, latch op, src_a, src_b, dst, imm into command registers; inputs may change afterwards.
- TA: bus = operand A source; Y <= bus. Source A is reg[src_a] for MOV/ADD/SUB/AND/OR/MUL, cmd_imm for LDI, HI for MFHI.
- TB: bus = reg[src_b]. Z (2·WIDTH) <= f(Y, bus):
  - MOV/LDI/MFHI: Z_LO = Y, Z_HI = 0
  - ADD: Y+bus mod 2^WIDTH; SUB: Y−bus mod 2^WIDTH (carry/borrow discarded)
  - AND/OR: bitwise
  - MUL: unsigned full product, Z_HI:Z_LO = Y·bus
- TW: bus = Z_LO; reg[dst] <= bus at the closing edge; for MUL also HI <= Z_HI. done = 1 for exactly this cycle. zero <= (Z_LO == 0).
- IDLE: bus drives 0.
- dst equals a source: both sources are read in TA/TB before the TW write, so the old value is used.
- R0_ZERO=1 and dst=0: the write is suppressed and done still pulses. zero reflects Z_LO.
- Operands that read R0 with R0_ZERO=1 read 0.
- For MUL, HI updates even if the dst write is suppressed.

## Timing
- Reset (clear high, any state, asynchronous): state IDLE; all registers, HI, Y, Z and command latches reset to 0. Outputs: cmd_ready=1, done=0, zero=0, bus_out=0, hi_data=0, dbg_data=0.
- Reset mid-operation aborts the command with no register write and no done pulse.
- Latency: command accepted at edge k; TA in cycle k→k+1, TB in k+1→k+2, TW in k+2→k+3; result visible on dbg_data after edge k+3.
- cmd_ready rises after edge k+3, so the next accept is at edge k+4 at the earliest. Throughput is one command per 4 cycles.
- cmd_ready is low in TA/TB/TW; cmd_valid is ignored there, and there is no queueing.
- cmd_ready is a function of state only, with no combinational path from cmd_valid.
- bus_out is combinational from state and registers, stable within each state cycle.

## Test plan
- Reset, then LDI dst=3 imm=0x0000_00A5 → done high in the third cycle after accept; dbg_sel=3 gives 0x0000_00A5; zero=0; cmd_ready low for exactly 3 cycles.
- LDI R1=0xFFFF_FFFF, LDI R2=1, ADD dst=4 a=1 b=2 → R4=0, zero=1. SUB dst=5 a=2 b=1 → R5=0x0000_0002.
- MUL a=R1 (0xFFFF_FFFF) b=R1 dst=6 → R6=0x0000_0001 and HI=0xFFFF_FFFE. Then MFHI dst=7 → R7=0xFFFF_FFFE.
- R0_ZERO=1: LDI dst=0 imm=5 → done pulses and R0 reads 0. MOV dst=8 a=0 → R8=0. Repeat with R0_ZERO=0 → R0=5.
- Hold cmd_valid high continuously with varying fields → exactly one accept per 4 cycles; fields changed during TA–TW have no effect.
- Assert clear during TB of ADD dst=9 → R9 stays 0, no done pulse, cmd_ready=1 immediately. Also run with WIDTH=8, NREGS=4: ADD 0xF0+0x20 → 0x10.

Source files
------------

// File: rtl/bus_xfer_unit.sv
// bus_xfer_unit
//   Single-bus register-transfer datapath with its own three-phase sequencer.
//   It accepts one command at a time over a valid/ready port. Each command
//   runs through three phases:
//     TA - the operand A source drives the bus, and Y captures it.
//     TB - reg[src_b] drives the bus, and Z captures f(Y, bus).
//     TW - Z_LO drives the bus, and the destination register captures it.
//
// Ports
//   clock, clear           rising-edge clock, asynchronous active-high reset
//   cmd_valid / cmd_ready  command handshake (ready only while idle)
//   cmd_op                 0 MOV, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 MUL, 7 MFHI
//   cmd_src_a/_b, cmd_dst  register indices; cmd_imm is the LDI immediate
//   done                   one-cycle pulse during the write phase
//   zero                   registered "written value was zero" flag
//   bus_out                current bus contents
//   dbg_sel / dbg_data     combinational register read-back
//   hi_data                HI register (upper half of the last MUL)
module bus_xfer_unit #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter bit R0_ZERO = 1'b0,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_src_a,
  input  logic [AW-1:0]    cmd_src_b,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic             zero,
  output logic [WIDTH-1:0] bus_out,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] hi_data
);

  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_MFHI = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_TA, S_TB, S_TW} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;

  logic [2:0]         r_op;
  logic [AW-1:0]      r_src_a;
  logic [AW-1:0]      r_src_b;
  logic [AW-1:0]      r_dst;
  logic [WIDTH-1:0]   r_imm;

  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [WIDTH-1:0]   w_view [NREGS];
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_z;
  logic [2*WIDTH-1:0] w_z_next;
  logic               r_zero;
  logic [WIDTH-1:0]   w_bus;
  logic               w_wr_en;

  // This is the register file as seen by every reader. When R0_ZERO is set,
  // R0 is tied to zero here. Its storage is never written in that case either.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_view
    if (gi == 0 && R0_ZERO) begin : g_r0_zero
      assign w_view[gi] = '0;
    end else begin : g_reg
      assign w_view[gi] = r_regs[gi];
    end
  end

  // Sequencer state register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Sequencer next state. cmd_valid is looked at only while idle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_valid) begin
        w_state_next = S_TA;
        w_accept     = 1'b1;
      end
      S_TA:    w_state_next = S_TB;
      S_TB:    w_state_next = S_TW;
      S_TW:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus source selection. It depends only on the state and the registers.
  always_comb begin
    w_bus = '0;
    case (r_state)
      S_TA: begin
        case (r_op)
          OP_LDI:  w_bus = r_imm;
          OP_MFHI: w_bus = r_hi;
          default: w_bus = w_view[r_src_a];
        endcase
      end
      S_TB:    w_bus = w_view[r_src_b];
      S_TW:    w_bus = r_z[WIDTH-1:0];
      default: w_bus = '0;
    endcase
  end

  // ALU feeding Z during TB.
  // Moves (MOV/LDI/MFHI) pass Y through with Z_HI cleared.
  always_comb begin
    w_z_next = {{WIDTH{1'b0}}, r_y};
    case (r_op)
      OP_ADD:  w_z_next = {{WIDTH{1'b0}}, r_y + w_bus};
      OP_SUB:  w_z_next = {{WIDTH{1'b0}}, r_y - w_bus};
      OP_AND:  w_z_next = {{WIDTH{1'b0}}, r_y & w_bus};
      OP_OR:   w_z_next = {{WIDTH{1'b0}}, r_y | w_bus};
      OP_MUL:  w_z_next = {{WIDTH{1'b0}}, r_y} * {{WIDTH{1'b0}}, w_bus};
      default: w_z_next = {{WIDTH{1'b0}}, r_y};
    endcase
  end

  assign w_wr_en = !(R0_ZERO && (r_dst == '0));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_op    <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_imm   <= '0;
      r_hi    <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_zero  <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= cmd_op;
        r_src_a <= cmd_src_a;
        r_src_b <= cmd_src_b;
        r_dst   <= cmd_dst;
        r_imm   <= cmd_imm;
      end
      if (r_state == S_TA) r_y <= w_bus;
      if (r_state == S_TB) r_z <= w_z_next;
      if (r_state == S_TW) begin
        // Both sources were read in TA/TB, so a dst that aliases a source
        // has already contributed its old value.
        if (w_wr_en) r_regs[r_dst] <= w_bus;
        // HI still updates when the R0 write is suppressed.
        if (r_op == OP_MUL) r_hi <= r_z[2*WIDTH-1:WIDTH];
        r_zero <= (r_z[WIDTH-1:0] == '0);
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign done      = (r_state == S_TW);
  assign zero      = r_zero;
  assign bus_out   = w_bus;
  assign dbg_data  = w_view[dbg_sel];
  assign hi_data   = r_hi;

endmodule

// File: tb/tb_bus_xfer_unit.sv
module tb_bus_xfer_unit;

  localparam logic [2:0] OP_MOV  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_MFHI = 3'd7;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  // Instance A: 32-bit, 16 registers, R0 is an ordinary register
  logic        a_valid = 1'b0, a_ready, a_done, a_zero;
  logic [2:0]  a_op = '0;
  logic [3:0]  a_src_a = '0, a_src_b = '0, a_dst = '0, a_dbg = '0;
  logic [31:0] a_imm = '0, a_bus, a_dbg_data, a_hi;

  bus_xfer_unit #(.WIDTH(32), .NREGS(16), .R0_ZERO(1'b0)) u_a (
    .clock(clock), .clear(clear),
    .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op),
    .cmd_src_a(a_src_a), .cmd_src_b(a_src_b), .cmd_dst(a_dst), .cmd_imm(a_imm),
    .done(a_done), .zero(a_zero), .bus_out(a_bus),
    .dbg_sel(a_dbg), .dbg_data(a_dbg_data), .hi_data(a_hi)
  );

  // Instance B: 8-bit, 4 registers, R0 hard-wired to zero
  logic        b_valid = 1'b0, b_ready, b_done, b_zero;
  logic [2:0]  b_op = '0;
  logic [1:0]  b_src_a = '0, b_src_b = '0, b_dst = '0, b_dbg = '0;
  logic [7:0]  b_imm = '0, b_bus, b_dbg_data, b_hi;

  bus_xfer_unit #(.WIDTH(8), .NREGS(4), .R0_ZERO(1'b1)) u_b (
    .clock(clock), .clear(clear),
    .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
    .cmd_src_a(b_src_a), .cmd_src_b(b_src_b), .cmd_dst(b_dst), .cmd_imm(b_imm),
    .done(b_done), .zero(b_zero), .bus_out(b_bus),
    .dbg_sel(b_dbg), .dbg_data(b_dbg_data), .hi_data(b_hi)
  );

  int tests  = 0;
  int failed = 0;

  // Architectural model of instance A
  logic [31:0] m_regs [16];
  logic [31:0] m_hi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_hi = '0;
  endtask

  // Apply one instruction to the model.
  // Returns the operand A value, the operand B value and the result written.
  task automatic model_apply(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] d, input logic [31:0] imm,
                             output logic [31:0] opa, output logic [31:0] opb,
                             output logic [31:0] lo);
    logic [63:0] full;
    opa = (op == OP_LDI) ? imm : (op == OP_MFHI) ? m_hi : m_regs[a];
    opb = m_regs[b];
    case (op)
      OP_ADD:  full = {32'd0, opa + opb};
      OP_SUB:  full = {32'd0, opa - opb};
      OP_AND:  full = {32'd0, opa & opb};
      OP_OR:   full = {32'd0, opa | opb};
      OP_MUL:  full = 64'(opa) * 64'(opb);
      default: full = {32'd0, opa};
    endcase
    lo = full[31:0];
    m_regs[d] = lo;
    if (op == OP_MUL) m_hi = full[63:32];
  endtask

  // Run one command on A and check every phase against the model.
  task automatic do_a(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] d, input logic [31:0] imm);
    logic [31:0] opa, opb, lo;
    model_apply(op, a, b, d, imm, opa, opb, lo);
    @(negedge clock);
    chk("a_idle_ready", a_ready, 1'b1);
    a_valid = 1'b1; a_op = op; a_src_a = a; a_src_b = b; a_dst = d; a_imm = imm;
    @(posedge clock); #1;
    // Scramble the inputs; the latched command must be unaffected.
    a_valid = 1'b0; a_op = 3'($urandom); a_src_a = 4'($urandom);
    a_src_b = 4'($urandom); a_dst = 4'($urandom); a_imm = $urandom;
    chk("a_ta_ready", a_ready, 1'b0);
    chk("a_ta_done", a_done, 1'b0);
    chk("a_ta_bus", a_bus, opa);
    @(posedge clock); #1;
    chk("a_tb_ready", a_ready, 1'b0);
    chk("a_tb_done", a_done, 1'b0);
    chk("a_tb_bus", a_bus, opb);
    @(posedge clock); #1;
    chk("a_tw_ready", a_ready, 1'b0);
    chk("a_tw_done", a_done, 1'b1);
    chk("a_tw_bus", a_bus, lo);
    @(posedge clock); #1;
    chk("a_end_ready", a_ready, 1'b1);
    chk("a_end_done", a_done, 1'b0);
    chk("a_end_bus", a_bus, 32'd0);
    chk("a_zero", a_zero, (lo == 32'd0));
    chk("a_hi", a_hi, m_hi);
    a_dbg = d; #1;
    chk("a_dst_value", a_dbg_data, m_regs[d]);
  endtask

  // Run one command on B and check the done latency and the destination value.
  task automatic do_b(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] d, input logic [7:0] imm, input logic [7:0] exp);
    int n;
    @(negedge clock);
    b_valid = 1'b1; b_op = op; b_src_a = a; b_src_b = b; b_dst = d; b_imm = imm;
    @(posedge clock); #1;
    b_valid = 1'b0; b_op = 3'($urandom); b_imm = 8'($urandom);
    n = 0;
    while (b_done !== 1'b1 && n < 8) begin
      @(posedge clock); #1;
      n++;
    end
    chk("b_done_latency", n, 2);
    @(posedge clock); #1;
    chk("b_done_pulse", b_done, 1'b0);
    b_dbg = d; #1;
    chk("b_dst_value", b_dbg_data, exp);
  endtask

  initial begin
    logic [31:0] opa, opb, lo;
    model_reset();

    // Reset state
    #2;
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_done", a_done, 1'b0);
    chk("rst_zero", a_zero, 1'b0);
    chk("rst_bus", a_bus, 32'd0);
    chk("rst_hi", a_hi, 32'd0);
    chk("rst_dbg", a_dbg_data, 32'd0);
    chk("rst_b_ready", b_ready, 1'b1);
    @(negedge clock);
    clear = 1'b0;

    // Narrow instance with R0 hard-wired to zero
    do_b(OP_LDI, 2'd0, 2'd0, 2'd1, 8'hF0, 8'hF0);
    do_b(OP_LDI, 2'd0, 2'd0, 2'd2, 8'h20, 8'h20);
    do_b(OP_ADD, 2'd1, 2'd2, 2'd3, 8'h00, 8'h10);
    do_b(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h05, 8'h00);
    do_b(OP_MOV, 2'd0, 2'd0, 2'd2, 8'h00, 8'h00);
    do_b(OP_MUL, 2'd1, 2'd3, 2'd0, 8'h00, 8'h00);   // F0*10 = 0F00, dst R0 suppressed
    chk("b_mul_hi_r0", b_hi, 8'h0F);

    // Directed sequence on the wide instance
    do_a(OP_LDI, 4'd0, 4'd0, 4'd3, 32'h0000_00A5);
    do_a(OP_LDI, 4'd0, 4'd0, 4'd1, 32'hFFFF_FFFF);
    do_a(OP_LDI, 4'd0, 4'd0, 4'd2, 32'h0000_0001);
    do_a(OP_ADD, 4'd1, 4'd2, 4'd4, 32'd0);
    chk("add_wrap_zero", a_zero, 1'b1);
    do_a(OP_SUB, 4'd2, 4'd1, 4'd5, 32'd0);
    do_a(OP_MUL, 4'd1, 4'd1, 4'd6, 32'd0);
    chk("mul_hi", a_hi, 32'hFFFF_FFFE);
    do_a(OP_MFHI, 4'd0, 4'd0, 4'd7, 32'd0);
    do_a(OP_LDI, 4'd0, 4'd0, 4'd0, 32'd5);
    do_a(OP_MOV, 4'd0, 4'd0, 4'd8, 32'd0);
    do_a(OP_ADD, 4'd3, 4'd3, 4'd3, 32'd0);          // dst aliases both sources

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] imm;
      op  = 3'($urandom_range(0, 7));
      imm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      do_a(op, 4'($urandom), 4'($urandom), 4'($urandom), imm);
    end

    // cmd_valid held high with fields changing every cycle
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      a_valid = 1'b1; a_op = 3'($urandom); a_src_a = 4'($urandom);
      a_src_b = 4'($urandom); a_dst = 4'($urandom); a_imm = $urandom;
      chk("hold_ready", a_ready, (i % 4 == 0));
      chk("hold_done", a_done, (i % 4 == 3));
      if (i % 4 == 0) model_apply(a_op, a_src_a, a_src_b, a_dst, a_imm, opa, opb, lo);
      @(negedge clock);
    end
    a_valid = 1'b0;
    for (int r = 0; r < 16; r++) begin
      a_dbg = 4'(r); #1;
      chk("hold_regs", a_dbg_data, m_regs[r]);
    end
    chk("hold_hi", a_hi, m_hi);

    // Reset during TB of ADD dst=9
    do_a(OP_LDI, 4'd0, 4'd0, 4'd9, 32'h1234_5678);
    @(negedge clock);
    a_valid = 1'b1; a_op = OP_ADD; a_src_a = 4'd1; a_src_b = 4'd2; a_dst = 4'd9;
    @(posedge clock); #1;
    a_valid = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1; #1;
    model_reset();
    chk("abort_ready", a_ready, 1'b1);
    chk("abort_done", a_done, 1'b0);
    chk("abort_bus", a_bus, 32'd0);
    chk("abort_hi", a_hi, 32'd0);
    a_dbg = 4'd9; #1;
    chk("abort_r9", a_dbg_data, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("abort_no_done", a_done, 1'b0);
    end
    do_a(OP_SUB, 4'd9, 4'd9, 4'd9, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
